// File: rtl/uart_rx.sv
// 8n1 UART receiver with OVS-times oversampling and a 2-flop input synchronizer.
// Optional 2-of-3 sample voting is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx #(
    parameter int OVS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic [7:0] data,
    output logic       data_rdy,
    output logic       frame_err
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic          s1, s2;
    logic [1:0]    warm;
    logic          prev;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    bitn;
    logic [7:0]    shreg;
    logic          sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic h1, h2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= 1'b1;
            h2 <= 1'b1;
        end else begin
            h1 <= s2;
            h2 <= h1;
        end
    end

    assign sample = (h1 & h2) | (h1 & s2) | (h2 & s2);
`else
    assign sample = s2;
`endif

    // The reset-forced 1s in the synchronizer are not real line history, so a
    // falling edge is only recognised once s2 carries sampled line values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm <= 2'b00;
            prev <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            prev <= warm[1] ? s2 : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bitn      <= 4'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            data_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            data_rdy  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s2 && prev) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        bitn  <= 4'd0;
                        state <= sample ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= {sample, shreg[7:1]};
                        if (bitn == 4'd7) begin
                            bitn  <= 4'd0;
                            state <= STOP;
                        end else begin
                            bitn <= bitn + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (sample) begin
                            data     <= shreg;
                            data_rdy <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (s2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at OVS = 16; one task per scenario.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in;
    logic [7:0] data;
    logic       data_rdy;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int cyc = 0, rdy_cnt = 0, err_cnt = 0, both_cnt = 0;
    int rdy_cyc = 0, err_cyc = 0, t_start = 0;
    int rdy_base, err_base;

    // Start bit driven before posedge 1; 2 sync flops, OVS/2 + 9*OVS to the
    // stop sample, one more edge to register the pulse: 2 + 8 + 144 + 1.
    localparam int LAT = 155;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] GLITCH_EXP = 8'h55;
`else
    localparam logic [7:0] GLITCH_EXP = 8'hAA;
`endif

    uart_rx #(.OVS(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in(in),
        .data(data),
        .data_rdy(data_rdy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_rdy) begin
            rdy_cnt <= rdy_cnt + 1;
            rdy_cyc <= cyc;
        end
        if (frame_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (data_rdy && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic idle(input int n);
        in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic glitch);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            if (glitch && i >= 1 && i <= 8) begin
                in = f[i];
                repeat (8) @(negedge clk);
                in = ~f[i];
                @(negedge clk);
                in = f[i];
                repeat (7) @(negedge clk);
            end else begin
                in = f[i];
                repeat (16) @(negedge clk);
            end
        end
        in = 1'b1;
    endtask

    task automatic mark;
        rdy_base = rdy_cnt;
        err_base = err_cnt;
    endtask

    task automatic test_reset;
        total++;
        if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
        total++;
        if (data_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", data_rdy); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        idle(20);
        total++;
        if (rdy_cnt + err_cnt !== 0) begin bad++; $display("FAIL reset_idle_pulses: got %0d want 0", rdy_cnt + err_cnt); end
    endtask

    task automatic test_frame;
        mark();
        send_frame(8'hA5, 1'b1, 1'b0);
        total++;
        if (data !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", data); end
        total++;
        if (rdy_cnt - rdy_base !== 1) begin bad++; $display("FAIL a5_rdy_count: got %0d want 1", rdy_cnt - rdy_base); end
        total++;
        if (rdy_cyc - t_start !== LAT) begin bad++; $display("FAIL a5_latency: got %0d want %0d", rdy_cyc - t_start, LAT); end
        total++;
        if (err_cnt - err_base !== 0) begin bad++; $display("FAIL a5_err: got %0d want 0", err_cnt - err_base); end
        idle(10);
    endtask

    task automatic test_false_start;
        mark();
        in = 1'b0;
        repeat (4) @(negedge clk);
        idle(200);
        total++;
        if (rdy_cnt - rdy_base !== 0) begin bad++; $display("FAIL false_rdy: got %0d want 0", rdy_cnt - rdy_base); end
        total++;
        if (err_cnt - err_base !== 0) begin bad++; $display("FAIL false_err: got %0d want 0", err_cnt - err_base); end
        total++;
        if (data !== 8'hA5) begin bad++; $display("FAIL false_data: got %h want a5", data); end
    endtask

    task automatic test_frame_error;
        mark();
        send_frame(8'h3C, 1'b0, 1'b0);
        total++;
        if (err_cnt - err_base !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", err_cnt - err_base); end
        total++;
        if (err_cyc - t_start !== LAT) begin bad++; $display("FAIL ferr_latency: got %0d want %0d", err_cyc - t_start, LAT); end
        total++;
        if (rdy_cnt - rdy_base !== 0) begin bad++; $display("FAIL ferr_rdy: got %0d want 0", rdy_cnt - rdy_base); end
        total++;
        if (data !== 8'hA5) begin bad++; $display("FAIL ferr_data_kept: got %h want a5", data); end
        idle(20);
        mark();
        send_frame(8'h5A, 1'b1, 1'b0);
        total++;
        if (data !== 8'h5A) begin bad++; $display("FAIL ferr_next_data: got %h want 5a", data); end
        total++;
        if (rdy_cnt - rdy_base !== 1) begin bad++; $display("FAIL ferr_next_rdy: got %0d want 1", rdy_cnt - rdy_base); end
    endtask

    task automatic test_back_to_back;
        mark();
        send_frame(8'h00, 1'b1, 1'b0);
        total++;
        if (data !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", data); end
        send_frame(8'hFF, 1'b1, 1'b0);
        total++;
        if (data !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", data); end
        total++;
        if (rdy_cnt - rdy_base !== 2) begin bad++; $display("FAIL b2b_rdy_count: got %0d want 2", rdy_cnt - rdy_base); end
        total++;
        if (rdy_cyc - t_start !== LAT) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", rdy_cyc - t_start, LAT); end
        idle(10);
    endtask

    task automatic test_reset_midframe;
        logic [9:0] f;
        f = {1'b1, 8'h81, 1'b0};
        mark();
        for (int i = 0; i < 10; i++) begin
            in = f[i];
            if (i == 5) begin
                repeat (8) @(negedge clk);
                rst_n = 1'b0;
                #1;
                total++;
                if (data !== 8'h00) begin bad++; $display("FAIL midrst_data_async: got %h want 00", data); end
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
        end
        idle(60);
        total++;
        if (rdy_cnt - rdy_base !== 0) begin bad++; $display("FAIL midrst_rdy: got %0d want 0", rdy_cnt - rdy_base); end
        total++;
        if (err_cnt - err_base !== 0) begin bad++; $display("FAIL midrst_err: got %0d want 0", err_cnt - err_base); end
        total++;
        if (data !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", data); end
        mark();
        send_frame(8'h7E, 1'b1, 1'b0);
        total++;
        if (data !== 8'h7E) begin bad++; $display("FAIL midrst_next_data: got %h want 7e", data); end
        total++;
        if (rdy_cnt - rdy_base !== 1) begin bad++; $display("FAIL midrst_next_rdy: got %0d want 1", rdy_cnt - rdy_base); end
        idle(10);
    endtask

    task automatic test_glitch;
        mark();
        send_frame(8'h55, 1'b1, 1'b1);
        total++;
        if (data !== GLITCH_EXP) begin bad++; $display("FAIL glitch_data: got %h want %h", data, GLITCH_EXP); end
        total++;
        if (rdy_cnt - rdy_base !== 1) begin bad++; $display("FAIL glitch_rdy: got %0d want 1", rdy_cnt - rdy_base); end
        idle(10);
    endtask

    task automatic test_break_hold;
        mark();
        t_start = cyc;
        in = 1'b0;
        repeat (400) @(negedge clk);
        idle(40);
        total++;
        if (err_cnt - err_base !== 1) begin bad++; $display("FAIL break_err_count: got %0d want 1", err_cnt - err_base); end
        total++;
        if (err_cyc - t_start !== LAT) begin bad++; $display("FAIL break_latency: got %0d want %0d", err_cyc - t_start, LAT); end
        total++;
        if (rdy_cnt - rdy_base !== 0) begin bad++; $display("FAIL break_rdy: got %0d want 0", rdy_cnt - rdy_base); end
        total++;
        if (data !== GLITCH_EXP) begin bad++; $display("FAIL break_data_kept: got %h want %h", data, GLITCH_EXP); end
    endtask

    task automatic test_exclusive;
        total++;
        if (both_cnt !== 0) begin bad++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        in    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_frame();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_glitch();
        test_break_hold();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVS, default 16, clk cycles per UART bit (oversampling ratio); even, >= 8.
REQ-002 clk  input  1  receiver clock, OVS times the baud rate (e.g. 16 x 115.2 kHz).
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in  input  1  UART serial line, 8n1, idle high, LSB first, asynchronous to clk.
REQ-005 data  output  8  last correctly framed received byte.
REQ-006 data_rdy  output  1  one-cycle high pulse: data updated with a new byte; drives the write strobe of an external FIFO (n = 8).
REQ-007 frame_err  output  1  one-cycle high pulse: stop bit sampled low.

Function
REQ-008 in SHALL pass through a 2-flop synchronizer (s1 -> s2) before any use; all later references to "line" mean s2.
REQ-009 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-010 IDLE: first cycle with line = 0 is T0; the FSM SHALL enter START and clear the bit-phase counter.
REQ-011 START: the start bit SHALL be sampled at T0+OVS/2; sample 1 -> false start, return to IDLE, no output pulse; sample 0 -> DATA.
REQ-012 DATA: bit k (k = 0..7) SHALL be sampled at T0+OVS/2+(k+1)*OVS and shifted into an internal 8-bit register, LSB first.
REQ-013 STOP: the stop bit SHALL be sampled at T0+OVS/2+9*OVS (Ts).
REQ-014 Stop sample 1: data SHALL load the shift register and data_rdy SHALL pulse at Ts+1; FSM -> IDLE at Ts+1 (mid stop bit), so back-to-back frames are accepted.
REQ-015 Stop sample 0: frame_err SHALL pulse at Ts+1; data SHALL keep its previous value; FSM -> BREAK.
REQ-016 BREAK: FSM SHALL stay until line = 1, then return to IDLE; a held-low line SHALL yield exactly one frame_err.
REQ-017 data_rdy and frame_err SHALL never be high in the same cycle; each SHALL be high for exactly one cycle per frame.
REQ-018 data SHALL change only in the cycle data_rdy is asserted.
REQ-019 Line activity outside sample points (glitches, edges) SHALL not affect the FSM except as specified.
REQ-020 Bit-phase counter SHALL be ceil(log2(OVS)) bits wide and wrap at OVS-1; bit counter 4 bits.

Reset
REQ-021 rst_n low SHALL immediately force: FSM IDLE, counters 0, shift register 0, data 8'h00, data_rdy 0, frame_err 0, s1 = s2 = 1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no data_rdy or frame_err; after release, reception SHALL restart only on a new falling edge of line.

Configuration
REQ-023 Macro UART_RX_MAJORITY_EN defined: each sample point s (start, data, stop) SHALL take the 2-of-3 majority of line at s-2, s-1, s; timing of REQ-011..REQ-015 unchanged.
REQ-024 UART_RX_MAJORITY_EN undefined: each sample point SHALL use the single value of line at s; no vote registers instantiated.

Verification (OVS = 16; T0 = detection cycle)
REQ-025 Send 0xA5 at exact baud -> data = 0xA5, data_rdy single pulse at T0+153, frame_err stays 0.
REQ-026 Drive in low for 4 clk then high -> FSM returns to IDLE at T0+8, no data_rdy, no frame_err, data unchanged.
REQ-027 Send 0x3C with stop bit low, then line high -> frame_err pulse at T0+153, data keeps prior value, next frame 0x5A received as 0x5A.
REQ-028 Send 0x00 then 0xFF with no idle gap (one stop bit) -> two data_rdy pulses, data 0x00 then 0xFF.
REQ-029 Assert rst_n low during bit 4 of 0x81 -> data = 0x00, no pulses; following frame 0x7E received correctly.
REQ-030 With UART_RX_MAJORITY_EN: one-cycle inverting glitch on each data-bit sample point of 0x55 -> data = 0x55; without macro -> data = 0xAA.
